// File: rtl/gf_mul_pkg.sv
// Shared sizing helpers and controller state encoding for the GF(2^M) digit-serial multiplier.
// Optional macro GF_MUL_FMA_EN (used by the interface and top) adds the c accumulate operand.
package gf_mul_pkg;

  localparam int M_DEF = 163;
  localparam int D_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_ndig(input int m, input int d);
    return (m + d - 1) / d;
  endfunction

  function automatic int calc_ncyc(input int m, input int d, input int u);
    return (calc_ndig(m, d) + u - 1) / u;
  endfunction

  // Multiplier width after padding to a whole number of unrolled cycles.
  function automatic int calc_bw(input int m, input int d, input int u);
    return calc_ncyc(m, d, u) * u * d;
  endfunction

endpackage

// File: rtl/gf2m_digit_serial_mul_if.sv
// Operand/result handshake bundle for gf2m_digit_serial_mul.
// With GF_MUL_FMA_EN defined the bundle also carries the accumulate operand c.
interface gf2m_digit_serial_mul_if
  import gf_mul_pkg::*;
#(
  parameter int M = M_DEF
);
  logic         in_valid;
  logic         in_ready;
  logic [M-1:0] a;
  logic [M-1:0] b;
  logic [M-1:0] g;
`ifdef GF_MUL_FMA_EN
  logic [M-1:0] c;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [M-1:0] p;
  logic         busy;

`ifdef GF_MUL_FMA_EN
  modport master (output in_valid, a, b, g, c, out_ready,
                  input  in_ready, out_valid, p, busy);
  modport slave  (input  in_valid, a, b, g, c, out_ready,
                  output in_ready, out_valid, p, busy);
`else
  modport master (output in_valid, a, b, g, out_ready,
                  input  in_ready, out_valid, p, busy);
  modport slave  (input  in_valid, a, b, g, out_ready,
                  output in_ready, out_valid, p, busy);
`endif

endinterface

// File: rtl/gf_digit_cell.sv
// One combinational digit step: t_next = (t*x^D + a*b_digit) mod g, evaluated Horner-style
// so every intermediate stays reduced (degree < M).
module gf_digit_cell #(
  parameter int M = 163,
  parameter int D = 16
) (
  input  logic [M-1:0] t,
  input  logic [M-1:0] a,
  input  logic [M-1:0] g,
  input  logic [D-1:0] b_digit,
  output logic [M-1:0] t_next
);

  logic [M-1:0] w_acc;

  always_comb begin
    w_acc = t;
    for (int j = D - 1; j >= 0; j--) begin
      // Multiply by x, folding the overflowing x^M term back in via g.
      w_acc = {w_acc[M-2:0], 1'b0} ^ (w_acc[M-1] ? g : '0);
      if (b_digit[j]) begin
        w_acc = w_acc ^ a;
      end
    end
    t_next = w_acc;
  end

endmodule

// File: rtl/gf2m_digit_serial_mul.sv
// Folded digit-serial GF(2^M) multiplier: UNROLL chained digit cells per clock, MSB digit first.
// Defining GF_MUL_FMA_EN seeds the accumulator with c, giving p = a*b + c*x^BW mod g.
module gf2m_digit_serial_mul
  import gf_mul_pkg::*;
#(
  parameter int M      = M_DEF,
  parameter int D      = D_DEF,
  parameter int UNROLL = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  gf2m_digit_serial_mul_if.slave bus
);

  localparam int NCYC  = calc_ncyc(M, D, UNROLL);
  localparam int BW    = calc_bw(M, D, UNROLL);
  localparam int SHIFT = UNROLL * D;
  localparam int CW    = $clog2(NCYC + 1);

  state_t          r_state;
  state_t          w_state_next;
  logic [M-1:0]    r_a;
  logic [M-1:0]    r_g;
  logic [BW-1:0]   r_b;
  logic [M-1:0]    r_t;
  logic [CW-1:0]   r_cnt;
  logic [M-1:0]    r_p;
  logic            r_out_valid;
  logic            w_in_ready;
  logic            w_accept;
  logic            w_last;
  logic [M-1:0]    w_t [UNROLL+1];

  assign w_t[0] = r_t;

  // Cell gi consumes the gi-th most significant digit still left in r_b.
  for (genvar gi = 0; gi < UNROLL; gi++) begin : g_cell
    gf_digit_cell #(
      .M(M),
      .D(D)
    ) u_cell (
      .t      (w_t[gi]),
      .a      (r_a),
      .g      (r_g),
      .b_digit(r_b[BW-1-gi*D -: D]),
      .t_next (w_t[gi+1])
    );
  end

  assign w_last   = (r_cnt == CW'(NCYC - 1));
  assign w_accept = bus.in_valid && w_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_state_next = BUSY;
      end
      BUSY: begin
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        w_in_ready = bus.out_ready;
        if (bus.out_ready) w_state_next = bus.in_valid ? BUSY : IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_g         <= '0;
      r_b         <= '0;
      r_t         <= '0;
      r_cnt       <= '0;
      r_p         <= '0;
      r_out_valid <= 1'b0;
    end else begin
      // A result leaving DONE retires here; a same-edge accept below restarts the pipe.
      if (r_state == DONE && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_accept) begin
        r_a   <= bus.a;
        r_g   <= bus.g;
        r_b   <= BW'(bus.b);
`ifdef GF_MUL_FMA_EN
        r_t   <= bus.c;
`else
        r_t   <= '0;
`endif
        r_cnt <= '0;
      end else if (r_state == BUSY) begin
        r_t   <= w_t[UNROLL];
        r_b   <= r_b << SHIFT;
        r_cnt <= r_cnt + CW'(1);
        if (w_last) begin
          r_p         <= w_t[UNROLL];
          r_out_valid <= 1'b1;
        end
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.p         = r_p;
  assign bus.busy      = (r_state == BUSY);

endmodule

// File: tb/tb_gf2m_digit_serial_mul.sv
// Bench for gf2m_digit_serial_mul: GF(2^8) AES vectors (UNROLL 1 and 3), handshake/reset
// scenarios, and random GF(2^163) products checked against a long-division reference.
module tb_gf2m_digit_serial_mul;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Shared operand buses for the two GF(2^8) instances, separate handshakes.
  logic [7:0]   a8, b8, g8, c8;
  logic         iv1, or1, iv3, or3;
  logic [162:0] a163, b163, g163, c163;
  logic         iv163, or163;

  gf2m_digit_serial_mul_if #(.M(8))   if1 ();
  gf2m_digit_serial_mul_if #(.M(8))   if3 ();
  gf2m_digit_serial_mul_if #(.M(163)) if163 ();

  assign if1.a = a8;  assign if1.b = b8;  assign if1.g = g8;
  assign if1.in_valid = iv1;  assign if1.out_ready = or1;
  assign if3.a = a8;  assign if3.b = b8;  assign if3.g = g8;
  assign if3.in_valid = iv3;  assign if3.out_ready = or3;
  assign if163.a = a163;  assign if163.b = b163;  assign if163.g = g163;
  assign if163.in_valid = iv163;  assign if163.out_ready = or163;
`ifdef GF_MUL_FMA_EN
  assign if1.c = c8;
  assign if3.c = c8;
  assign if163.c = c163;
`endif

  gf2m_digit_serial_mul #(.M(8), .D(2), .UNROLL(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1));
  gf2m_digit_serial_mul #(.M(8), .D(2), .UNROLL(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(if3));
  gf2m_digit_serial_mul #(.M(163), .D(16), .UNROLL(1)) u_dut163 (
    .clk(clk), .rst_n(rst_n), .bus(if163));

  // Reference: full carry-less product plus c*x^bw, then polynomial long division by x^m + g.
  function automatic logic [255:0] ref_mul(input logic [255:0] a, input logic [255:0] b,
                                           input logic [255:0] c, input logic [255:0] g,
                                           input int m, input int bw);
    logic [511:0] acc;
    logic [511:0] poly;
    acc  = '0;
    poly = {256'b0, g} | (512'b1 << m);
    for (int i = 0; i < m; i++)
      if (b[i]) acc = acc ^ ({256'b0, a} << i);
    acc = acc ^ ({256'b0, c} << bw);
    for (int i = 511; i >= m; i--)
      if (acc[i]) acc = acc ^ (poly << (i - m));
    return acc[255:0];
  endfunction

  function automatic logic [162:0] rand163();
    logic [191:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return r[162:0];
  endfunction

  // One operation on a GF(2^8) instance (sel=1 picks UNROLL=3); returns result and latency.
  task automatic op8(input bit sel, input logic [7:0] a_in, input logic [7:0] b_in,
                     output logic [7:0] p_out, output int lat);
    bit done;
    @(negedge clk);
    a8 = a_in; b8 = b_in;
    if (sel) iv3 = 1'b1; else iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0; iv3 = 1'b0;
    lat = 0; done = 0;
    while (!done && lat < 50) begin
      @(posedge clk); #1;
      lat++;
      if (sel ? if3.out_valid : if1.out_valid) done = 1;
    end
    if (!done) begin
      n_cmp++; n_mis++;
      $display("FAIL op8_timeout: out_valid=0 after %0d cycles, required 1", lat);
    end
    p_out = sel ? if3.p : if1.p;
    @(negedge clk);
    if (sel) or3 = 1'b1; else or1 = 1'b1;
    @(posedge clk); #1;
    or1 = 1'b0; or3 = 1'b0;
  endtask

  task automatic op163(input logic [162:0] a_in, input logic [162:0] b_in,
                       input logic [162:0] c_in, output logic [162:0] p_out, output int lat);
    bit done;
    @(negedge clk);
    a163 = a_in; b163 = b_in; c163 = c_in; iv163 = 1'b1;
    @(posedge clk); #1;
    iv163 = 1'b0;
    lat = 0; done = 0;
    while (!done && lat < 50) begin
      @(posedge clk); #1;
      lat++;
      if (if163.out_valid) done = 1;
    end
    if (!done) begin
      n_cmp++; n_mis++;
      $display("FAIL op163_timeout: out_valid=0 after %0d cycles, required 1", lat);
    end
    p_out = if163.p;
    @(negedge clk);
    or163 = 1'b1;
    @(posedge clk); #1;
    or163 = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] got;
    logic [3:0] exp;
    exp = 4'b0001;
    got = {if1.out_valid, if1.busy, |if1.p, if1.in_ready};
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL reset_u1 {ov,busy,|p,in_ready}: got %b required %b", got, exp);
    end
    got = {if3.out_valid, if3.busy, |if3.p, if3.in_ready};
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL reset_u3 {ov,busy,|p,in_ready}: got %b required %b", got, exp);
    end
    got = {if163.out_valid, if163.busy, |if163.p, if163.in_ready};
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL reset_u163 {ov,busy,|p,in_ready}: got %b required %b", got, exp);
    end
  endtask

  task automatic test_aes_vectors();
    logic [7:0] va [4] = '{8'h57, 8'h80, 8'h01, 8'h00};
    logic [7:0] vb [4] = '{8'h83, 8'h02, 8'hA5, 8'hFF};
    logic [7:0] vp [4] = '{8'hC1, 8'h1B, 8'hA5, 8'h00};
    logic [7:0] p;
    int lat;
    for (int i = 0; i < 4; i++) begin
      op8(1'b0, va[i], vb[i], p, lat);
      $display("aes u1 a=%h b=%h p=%h lat=%0d", va[i], vb[i], p, lat);
      n_cmp++;
      if (p !== vp[i]) begin
        n_mis++;
        $display("FAIL aes_u1_p: got %h required %h", p, vp[i]);
      end
      n_cmp++;
      if (lat !== 4) begin
        n_mis++;
        $display("FAIL aes_u1_latency: got %0d required 4", lat);
      end
    end
  endtask

  task automatic test_unroll3();
    logic [7:0] p;
    int lat;
    op8(1'b1, 8'h57, 8'h83, p, lat);
    $display("aes u3 a=57 b=83 p=%h lat=%0d", p, lat);
    n_cmp++;
    if (p !== 8'hC1) begin
      n_mis++;
      $display("FAIL aes_u3_p: got %h required c1", p);
    end
    n_cmp++;
    if (lat !== 2) begin
      n_mis++;
      $display("FAIL aes_u3_latency: got %0d required 2", lat);
    end
  endtask

  task automatic test_random8();
    logic [7:0] a, b, p, e;
    int lat;
    for (int i = 0; i < 40; i++) begin
      bit sel;
      sel = (i % 2) == 1;
      a = 8'($urandom());
      b = 8'($urandom());
      e = 8'(ref_mul(256'(a), 256'(b), 256'(c8), 256'(g8), 8, sel ? 12 : 8));
      op8(sel, a, b, p, lat);
      $display("rand8 u%0d a=%h b=%h p=%h exp=%h lat=%0d", sel ? 3 : 1, a, b, p, e, lat);
      n_cmp++;
      if (p !== e || lat !== (sel ? 2 : 4)) begin
        n_mis++;
        $display("FAIL rand8_u%0d: got p=%h lat=%0d required p=%h lat=%0d",
                 sel ? 3 : 1, p, lat, e, sel ? 2 : 4);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    bit done;
    int extra;
    @(negedge clk);
    a8 = 8'h57; b8 = 8'h83; iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0;
    done = 0; lat = 0;
    while (!done && lat < 50) begin
      @(posedge clk); #1; lat++;
      if (if1.out_valid) done = 1;
    end
    // Hold backpressure: result must stay put and no new operands accepted.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if (if1.out_valid !== 1'b1 || if1.p !== 8'hC1 || if1.in_ready !== 1'b0) begin
        n_mis++;
        $display("FAIL backpressure_hold cyc %0d: got ov=%b p=%h rdy=%b required ov=1 p=c1 rdy=0",
                 k, if1.out_valid, if1.p, if1.in_ready);
      end
    end
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h02; iv1 = 1'b1; or1 = 1'b1;
    #1;
    n_cmp++;
    if (if1.in_ready !== 1'b1) begin
      n_mis++;
      $display("FAIL b2b_in_ready: got %b required 1", if1.in_ready);
    end
    @(posedge clk); #1;
    iv1 = 1'b0; or1 = 1'b0;
    n_cmp++;
    if (if1.out_valid !== 1'b0 || if1.busy !== 1'b1) begin
      n_mis++;
      $display("FAIL b2b_retire_accept: got ov=%b busy=%b required ov=0 busy=1",
               if1.out_valid, if1.busy);
    end
    done = 0; lat = 0;
    while (!done && lat < 50) begin
      @(posedge clk); #1; lat++;
      if (if1.out_valid) done = 1;
    end
    $display("b2b u1 a=80 b=02 p=%h lat=%0d", if1.p, lat);
    n_cmp++;
    if (if1.p !== 8'h1B || lat !== 4) begin
      n_mis++;
      $display("FAIL b2b_second: got p=%h lat=%0d required p=1b lat=4", if1.p, lat);
    end
    @(negedge clk); or1 = 1'b1;
    @(posedge clk); #1; or1 = 1'b0;
    extra = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (if1.out_valid) extra++;
    end
    n_cmp++;
    if (extra !== 0) begin
      n_mis++;
      $display("FAIL b2b_no_duplicate: got %0d extra valid cycles required 0", extra);
    end
  endtask

  task automatic test_reset_midop();
    int spurious;
    logic [7:0] p;
    int lat;
    @(negedge clk);
    a8 = 8'h01; b8 = 8'hA5; iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (if1.out_valid !== 1'b0 || if1.p !== 8'h00 || if1.busy !== 1'b0) begin
      n_mis++;
      $display("FAIL reset_midop_async: got ov=%b p=%h busy=%b required ov=0 p=00 busy=0",
               if1.out_valid, if1.p, if1.busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (if1.in_ready !== 1'b1) begin
      n_mis++;
      $display("FAIL reset_midop_in_ready: got %b required 1", if1.in_ready);
    end
    spurious = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (if1.out_valid) spurious++;
    end
    n_cmp++;
    if (spurious !== 0) begin
      n_mis++;
      $display("FAIL reset_midop_spurious: got %0d valid cycles required 0", spurious);
    end
    op8(1'b0, 8'h57, 8'h83, p, lat);
    $display("post-reset u1 a=57 b=83 p=%h lat=%0d", p, lat);
    n_cmp++;
    if (p !== 8'hC1 || lat !== 4) begin
      n_mis++;
      $display("FAIL reset_recover: got p=%h lat=%0d required p=c1 lat=4", p, lat);
    end
  endtask

  task automatic test_random163();
    logic [162:0] a, b, c, p, e;
    int lat;
    for (int i = 0; i < 1000; i++) begin
      a = rand163();
      b = rand163();
      if (i == 0) b = '0;
      if (i == 1) begin a = 163'd1; b = '1; end
`ifdef GF_MUL_FMA_EN
      c = rand163();
`else
      c = '0;
`endif
      e = 163'(ref_mul(256'(a), 256'(b), 256'(c), 256'(g163), 163, 176));
      op163(a, b, c, p, lat);
      $display("rand163 #%0d p=%h exp=%h lat=%0d", i, p, e, lat);
      n_cmp++;
      if (p !== e) begin
        n_mis++;
        $display("FAIL rand163_p #%0d: got %h required %h", i, p, e);
      end
      n_cmp++;
      if (lat !== 11) begin
        n_mis++;
        $display("FAIL rand163_latency #%0d: got %0d required 11", i, lat);
      end
    end
  endtask

  initial begin
    a8 = '0; b8 = '0; g8 = 8'h1B; c8 = '0;
    iv1 = 1'b0; or1 = 1'b0; iv3 = 1'b0; or3 = 1'b0;
    a163 = '0; b163 = '0; c163 = '0; g163 = 163'hC9;
    iv163 = 1'b0; or163 = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    test_reset();
    test_aes_vectors();
    test_unroll3();
    test_random8();
    test_back_to_back();
    test_reset_midop();
    test_random163();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
